keypad_pin_check: RTL and testbench

KEYPAD_PIN_CHECK -- requirements
Module: keypad_pin_check

---
 rtl/keypad_pin_check.sv | 200 ++++++++++++++++++++
 tb/tb_keypad_pin_check.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_pin_check.sv
// Keypad PIN checker: collects four BCD digits, compares them to PIN on '#',
// pulses the door lock on a match. Optional lockout via `KEYPAD_LOCKOUT_EN.
module keypad_pin_check #(
    parameter logic [15:0] PIN            = 16'h1234,
    parameter int unsigned UNLOCK_CYCLES  = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned LOCK_CYCLES    = 1_500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_num,
    input  logic       room_booked,
    output logic       unlock_signal,
    output logic       deny,
    output logic       locked_out,
    output logic       entry_active,
    output logic [2:0] digit_count
);

    localparam int unsigned MAX_UT =
        (UNLOCK_CYCLES > TIMEOUT_CYCLES) ? UNLOCK_CYCLES : TIMEOUT_CYCLES;
`ifdef KEYPAD_LOCKOUT_EN
    localparam int unsigned MAX_C =
        (LOCK_CYCLES > MAX_UT) ? LOCK_CYCLES : MAX_UT;
`else
    localparam int unsigned MAX_C = MAX_UT;
`endif
    localparam int TW = (MAX_C > 2) ? $clog2(MAX_C) : 1;

    localparam logic [TW-1:0] UNLOCK_LAST  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
`ifdef KEYPAD_LOCKOUT_EN
    localparam logic [TW-1:0] LOCK_LAST    = TW'(LOCK_CYCLES - 1);
    localparam int            FW           = $clog2(MAX_FAIL + 1);
    localparam logic [FW-1:0] FAIL_LIMIT   = FW'(MAX_FAIL);
`endif

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        GRANT,
`ifdef KEYPAD_LOCKOUT_EN
        LOCKOUT,
`endif
        DENY
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     buf_q, buf_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            unlock_q, unlock_d;
    logic            deny_q, deny_d;
    logic            active_q, active_d;
`ifdef KEYPAD_LOCKOUT_EN
    logic [FW-1:0]   fail_q, fail_d;
    logic [FW-1:0]   fail_inc;
    logic            lock_q, lock_d;
`endif

    logic is_digit;
    logic is_clr;
    logic is_ent;

    // Classify the key strobe; codes C-F never qualify
    always_comb begin
        is_digit = key_valid && (key_num <= 4'd9);
        is_clr   = key_valid && (key_num == 4'hA);
        is_ent   = key_valid && (key_num == 4'hB);
    end

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        timer_d = '0;
`ifdef KEYPAD_LOCKOUT_EN
        fail_d   = fail_q;
        fail_inc = (fail_q == FAIL_LIMIT) ? fail_q : fail_q + FW'(1);
`endif
        case (state_q)
            IDLE: begin
                if (is_digit) begin
                    buf_d   = {12'h000, key_num};
                    cnt_d   = 3'd1;
                    state_d = ENTRY;
                end
            end
            ENTRY: begin
                // An expiring timeout beats a key arriving in the same cycle
                if (timer_q == TIMEOUT_LAST) begin
                    state_d = IDLE;
                end else if (is_clr) begin
                    state_d = IDLE;
                end else if (is_ent) begin
                    state_d = CHECK;
                end else if (is_digit) begin
                    if (cnt_q < 3'd4) begin
                        buf_d = {buf_q[11:0], key_num};
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            CHECK: begin
                if (cnt_q == 3'd4 && buf_q == PIN && !room_booked) begin
                    state_d = GRANT;
                end else begin
                    state_d = DENY;
                end
            end
            GRANT: begin
`ifdef KEYPAD_LOCKOUT_EN
                fail_d = '0;
`endif
                if (timer_q == UNLOCK_LAST) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DENY: begin
`ifdef KEYPAD_LOCKOUT_EN
                fail_d  = fail_inc;
                state_d = (fail_inc == FAIL_LIMIT) ? LOCKOUT : IDLE;
`else
                state_d = IDLE;
`endif
            end
`ifdef KEYPAD_LOCKOUT_EN
            LOCKOUT: begin
                if (timer_q == LOCK_LAST) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (state_d != ENTRY && state_d != CHECK) begin
            buf_d = '0;
            cnt_d = '0;
        end

        unlock_d = (state_d == GRANT);
        deny_d   = (state_d == DENY);
        active_d = (state_d == ENTRY);
`ifdef KEYPAD_LOCKOUT_EN
        lock_d   = (state_d == LOCKOUT);
`endif
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            buf_q    <= '0;
            cnt_q    <= '0;
            timer_q  <= '0;
            unlock_q <= 1'b0;
            deny_q   <= 1'b0;
            active_q <= 1'b0;
`ifdef KEYPAD_LOCKOUT_EN
            fail_q   <= '0;
            lock_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            unlock_q <= unlock_d;
            deny_q   <= deny_d;
            active_q <= active_d;
`ifdef KEYPAD_LOCKOUT_EN
            fail_q   <= fail_d;
            lock_q   <= lock_d;
`endif
        end
    end

    assign unlock_signal = unlock_q;
    assign deny          = deny_q;
    assign entry_active  = active_q;
    assign digit_count   = cnt_q;
`ifdef KEYPAD_LOCKOUT_EN
    assign locked_out    = lock_q;
`else
    assign locked_out    = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_pin_check.sv
// Directed bench for keypad_pin_check: vector table of key sequences
// plus hand-written timing, timeout, reset and lockout sequences.
module tb_keypad_pin_check;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_num = 4'h0;
    logic       room_booked = 1'b0;
    logic       unlock_signal;
    logic       deny;
    logic       locked_out;
    logic       entry_active;
    logic [2:0] digit_count;

    int checks = 0;
    int failures = 0;
    int unlock_cnt = 0;
    int deny_cnt = 0;
    int lock_cnt = 0;

    keypad_pin_check #(
        .PIN(16'h1234),
        .UNLOCK_CYCLES(8),
        .TIMEOUT_CYCLES(100),
        .MAX_FAIL(3),
        .LOCK_CYCLES(50)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_valid(key_valid),
        .key_num(key_num),
        .room_booked(room_booked),
        .unlock_signal(unlock_signal),
        .deny(deny),
        .locked_out(locked_out),
        .entry_active(entry_active),
        .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] keys;
        int          n;
        logic        rb;
        int          exp_unlock;
        int          exp_deny;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (unlock_signal) unlock_cnt++;
        if (deny) deny_cnt++;
        if (locked_out) lock_cnt++;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_num = k;
        step();
        key_valid = 1'b0;
        key_num = 4'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        key_valid = 1'b0;
        room_booked = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        unlock_cnt = 0;
        deny_cnt = 0;
        lock_cnt = 0;
    endtask

    task automatic enter_pin(input logic [15:0] p);
        press(p[15:12]);
        press(p[11:8]);
        press(p[7:4]);
        press(p[3:0]);
        press(4'hB);
    endtask

    initial begin
        vt[0] = '{"pin_ok",      32'h1234B000, 5, 1'b0, 8, 0};
        vt[1] = '{"booked",      32'h1234B000, 5, 1'b1, 0, 1};
        vt[2] = '{"clear_retry", 32'h12A1234B, 8, 1'b0, 8, 0};
        vt[3] = '{"fifth_digit", 32'h12345B00, 6, 1'b0, 8, 0};
        vt[4] = '{"short_pin",   32'h123B0000, 4, 1'b0, 0, 1};
        vt[5] = '{"wrong_order", 32'h1243B000, 5, 1'b0, 0, 1};
        vt[6] = '{"idle_keys",   32'hBA000000, 2, 1'b0, 0, 0};
        vt[7] = '{"codes_c_f",   32'h1C2F34B0, 7, 1'b0, 8, 0};
        vt[8] = '{"nines",       32'h9999B000, 5, 1'b0, 0, 1};
        vt[9] = '{"clr_short",   32'h12A0B000, 5, 1'b0, 0, 1};

        // reset state
        #2;
        check("rst_unlock", int'(unlock_signal), 0);
        check("rst_deny", int'(deny), 0);
        check("rst_locked", int'(locked_out), 0);
        check("rst_active", int'(entry_active), 0);
        check("rst_count", int'(digit_count), 0);
        do_reset();

        // table-driven sequences
        for (int i = 0; i < 10; i++) begin
            do_reset();
            room_booked = vt[i].rb;
            for (int k = 0; k < vt[i].n; k++) begin
                press(vt[i].keys[31-4*k -: 4]);
            end
            repeat (12) step();
            check({vt[i].name, "_unlock"}, unlock_cnt, vt[i].exp_unlock);
            check({vt[i].name, "_deny"}, deny_cnt, vt[i].exp_deny);
            check({vt[i].name, "_cnt"}, int'(digit_count), 0);
            check({vt[i].name, "_lock"}, lock_cnt, 0);
        end

        // grant timing
        do_reset();
        press(4'h1);
        check("t_active", int'(entry_active), 1);
        check("t_cnt1", int'(digit_count), 1);
        press(4'h2);
        press(4'h3);
        press(4'h4);
        check("t_cnt4", int'(digit_count), 4);
        press(4'hB);
        check("t_check_cnt", int'(digit_count), 4);
        check("t_check_active", int'(entry_active), 0);
        check("t_check_unlock", int'(unlock_signal), 0);
        step();
        check("t_first_unlock", int'(unlock_signal), 1);
        check("t_grant_cnt", int'(digit_count), 0);
        repeat (7) step();
        check("t_last_unlock", int'(unlock_signal), 1);
        step();
        check("t_unlock_off", int'(unlock_signal), 0);
        check("t_unlock_len", unlock_cnt, 8);
        check("t_no_deny", deny_cnt, 0);

        // reset mid-grant
        do_reset();
        enter_pin(16'h1234);
        repeat (3) step();
        reset = 1'b1;
        #1;
        check("mid_rst_unlock", int'(unlock_signal), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) step();
        check("mid_rst_len", unlock_cnt, 3);
        check("mid_rst_active", int'(entry_active), 0);

        // entry timeout
        do_reset();
        press(4'h1);
        press(4'h2);
        check("to_cnt2", int'(digit_count), 2);
        repeat (99) step();
        check("to_before", int'(entry_active), 1);
        step();
        check("to_after", int'(entry_active), 0);
        check("to_cnt0", int'(digit_count), 0);
        press(4'hB);
        repeat (12) step();
        check("to_deny", deny_cnt, 0);
        check("to_unlock", unlock_cnt, 0);
        check("to_idle", int'(entry_active), 0);

        // key coincident with timeout is dropped
        do_reset();
        press(4'h1);
        repeat (99) step();
        press(4'h2);
        check("to_race_active", int'(entry_active), 0);
        check("to_race_cnt", int'(digit_count), 0);

`ifdef KEYPAD_LOCKOUT_EN
        // three denials lock the keypad
        do_reset();
        repeat (3) begin
            enter_pin(16'h9999);
            repeat (2) step();
        end
        check("lo_deny3", deny_cnt, 3);
        check("lo_locked", int'(locked_out), 1);
        enter_pin(16'h1234);
        repeat (60) step();
        check("lo_len", lock_cnt, 50);
        check("lo_released", int'(locked_out), 0);
        check("lo_ignored", unlock_cnt, 0);
        enter_pin(16'h1234);
        repeat (12) step();
        check("lo_after", unlock_cnt, 8);

        // a grant clears the fail count
        do_reset();
        repeat (2) begin
            enter_pin(16'h9999);
            repeat (2) step();
        end
        enter_pin(16'h1234);
        repeat (12) step();
        repeat (2) begin
            enter_pin(16'h9999);
            repeat (2) step();
        end
        check("gc_lock", lock_cnt, 0);
        check("gc_deny", deny_cnt, 4);
        check("gc_unlock", unlock_cnt, 8);
`else
        // no lockout: four denials, still open to the right PIN
        do_reset();
        repeat (4) begin
            enter_pin(16'h9999);
            repeat (2) step();
        end
        check("nl_deny4", deny_cnt, 4);
        check("nl_lock", lock_cnt, 0);
        enter_pin(16'h1234);
        repeat (12) step();
        check("nl_unlock", unlock_cnt, 8);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
